// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, RX/TX state encodings and the parity helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

  // Callers zero-extend narrower characters; padding zeros do not change the XOR.
  function automatic logic calc_parity(input int unsigned mode, input logic [7:0] data);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with show-ahead read data, occupancy count and overflow pulse.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     ovf
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             ovf_q;
  logic             full, do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      ovf_q <= push && !do_push;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign cnt     = cnt_q;
  assign ovf     = ovf_q;

endmodule

// File: rtl/uart_echo_fifo.sv
// UART receiver + FIFO + transmitter; echo mode retransmits received characters.
// Optional UART_ECHO_ERRDROP_EN: errored characters are not written in echo mode.
module uart_echo_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic                          txd,
  input  logic                          cts_n,
  input  logic                          echo_en,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_dat,
  output logic [DATA_BITS-1:0]          rx_dat,
  output logic                          rx_vld,
  output logic                          frm_err,
  output logic                          pty_err,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          tx_bsy
);

  localparam int unsigned CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != PAR_NONE);

  // Receive path
  logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_dat_q, rx_dat_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_vld_q, rx_vld_d, frm_err_q, frm_err_d, pty_err_q, pty_err_d;
  logic                 rx_tick;

  assign rx_tick = (rx_cnt_q == BIT_LAST);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    rx_dat_d   = rx_dat_q;
    rx_vld_d   = 1'b0;
    frm_err_d  = 1'b0;
    pty_err_d  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rxd_prev_q && !rxd_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rxd_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_tick) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rxd_sync_q, rx_sh_q[DATA_BITS-1:1]};
          rx_idx_d = rx_idx_q + 3'(1);
          if (rx_idx_q == IDX_LAST) rx_state_d = HAS_PAR ? RxParity : RxStop;
        end
      end
      RxParity: begin
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_par_d   = rxd_sync_q;
          rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_state_d = RxIdle;
          rx_vld_d   = 1'b1;
          rx_dat_d   = rx_sh_q;
          frm_err_d  = !rxd_sync_q;
          pty_err_d  = HAS_PAR && (rx_par_q != calc_parity(PARITY, 8'(rx_sh_q)));
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // FIFO write source selection
  logic                 fifo_push, fifo_pop, fifo_empty;
  logic [DATA_BITS-1:0] fifo_wdat, fifo_rdat;

`ifdef UART_ECHO_ERRDROP_EN
  assign fifo_push = echo_en ? (rx_vld_q && !frm_err_q && !pty_err_q) : wr_en;
`else
  assign fifo_push = echo_en ? rx_vld_q : wr_en;
`endif
  assign fifo_wdat = echo_en ? rx_dat_q : wr_dat;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (fifo_wdat),
    .pop      (fifo_pop),
    .pop_dat  (fifo_rdat),
    .empty    (fifo_empty),
    .cnt      (fifo_cnt),
    .ovf      (ovf)
  );

  // Transmit path
  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_tick;

  assign tx_tick = (tx_cnt_q == BIT_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    fifo_pop   = 1'b0;
    txd        = 1'b1;
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        if (!fifo_empty && !cts_n) begin
          fifo_pop   = 1'b1;
          tx_sh_d    = fifo_rdat;
          tx_par_d   = calc_parity(PARITY, 8'(fifo_rdat));
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        txd = 1'b0;
        if (tx_tick) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = TxData;
        end
      end
      TxData: begin
        txd = tx_sh_q[0];
        if (tx_tick) begin
          tx_cnt_d = '0;
          tx_sh_d  = tx_sh_q >> 1;
          tx_idx_d = tx_idx_q + 3'(1);
          if (tx_idx_q == IDX_LAST) tx_state_d = HAS_PAR ? TxParity : TxStop;
        end
      end
      TxParity: begin
        txd = tx_par_q;
        if (tx_tick) begin
          tx_cnt_d   = '0;
          tx_state_d = TxStop;
        end
      end
      TxStop: begin
        if (tx_tick) begin
          tx_cnt_d   = '0;
          tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      rx_dat_q   <= '0;
      rx_vld_q   <= 1'b0;
      frm_err_q  <= 1'b0;
      pty_err_q  <= 1'b0;
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
      rx_dat_q   <= rx_dat_d;
      rx_vld_q   <= rx_vld_d;
      frm_err_q  <= frm_err_d;
      pty_err_q  <= pty_err_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
    end
  end

  assign rx_dat  = rx_dat_q;
  assign rx_vld  = rx_vld_q;
  assign frm_err = frm_err_q;
  assign pty_err = pty_err_q;
  assign tx_bsy  = (tx_state_q != TxIdle);

endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
Parametrised UART bridge: receiver, synchronous FIFO and transmitter in one block. In echo mode, every received character is buffered and retransmitted on txd. In host mode, the FIFO is filled from a parallel write port instead. Adds configurable width, parity, buffering, CTS flow control and error/overflow reporting. Sits at the board-level serial port.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit (>=8); the bit timer is a counter of width $clog2(CLKS_PER_BIT).
DATA_BITS, 8, character width, 5..8, sent LSB first.
PARITY, 0, 0=none, 1=odd, 2=even.
FIFO_DEPTH, 8, FIFO entries, power of 2, >=2.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rxd  in  1  serial input, asynchronous, idle high
txd  out  1  serial output, idle high
cts_n  in  1  1 = TX must not start a new frame
echo_en  in  1  1 = RX feeds FIFO; 0 = host port feeds FIFO
wr_en  in  1  host write strobe, used only when echo_en=0
wr_dat  in  DATA_BITS  host write data
rx_dat  out  DATA_BITS  last received character
rx_vld  out  1  1-cycle pulse: rx_dat updated
frm_err  out  1  1-cycle pulse with rx_vld: stop bit sampled 0
pty_err  out  1  1-cycle pulse with rx_vld: parity mismatch
ovf  out  1  1-cycle pulse: write attempted on full FIFO, data dropped
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  occupancy
tx_bsy  out  1  TX frame in progress

Behaviour:
- Reset, synchronous active-high, clock clk. Reset values: txd=1, rx_dat=0, rx_vld/frm_err/pty_err/ovf=0, fifo_cnt=0, tx_bsy=0. Both FSMs go to IDLE and the FIFO pointers clear. Reset mid-frame aborts the frame; txd=1 on the cycle after reset is sampled.
- rxd passes through a 2-flop synchroniser, initialised to 1.
- RX FSM: IDLE -> START on synchronised 1->0 -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - START: sample at CLKS_PER_BIT/2. If the line is high, the start was false; return to IDLE with no pulse.
  - Each later bit is sampled CLKS_PER_BIT cycles after the previous sample.
  - rx_vld, rx_dat and the error flags assert the cycle after the stop-bit sample.
  - The FSM returns to IDLE immediately after the stop sample, so back-to-back frames are accepted.
- FIFO write source:
  - echo_en=1: write on rx_vld. wr_en is ignored.
  - echo_en=0: write on wr_en. RX still reports characters but does not write.
- FIFO full/empty:
  - Write to a full FIFO: drop the data and pulse ovf.
  - A write and a pop in the same cycle on a full FIFO both succeed; fifo_cnt is unchanged and ovf=0.
  - A pop never occurs on an empty FIFO.
- Pointers wrap modulo FIFO_DEPTH.
- TX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE. Each bit lasts CLKS_PER_BIT cycles.
  - In IDLE with fifo_cnt!=0 and cts_n=0: pop and load the shift register. txd=0 on the next cycle and tx_bsy=1.
  - cts_n is checked only in IDLE. A frame already started always completes.
  - After a full stop bit, tx_bsy=0. A new frame may start on the following cycle.
- Parity is the XOR of the DATA_BITS data bits; it is inverted for odd parity.
- Changing echo_en mid-frame takes effect at the next FIFO write decision only.

Optional Feature:
UART_ECHO_ERRDROP_EN
- Defined: in echo mode, a character with frm_err or pty_err is not written to the FIFO. Flags still pulse and ovf is not affected.
- Undefined: errored characters are written and echoed like good ones.

Decomposition:
- Package uart_pkg:
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - RX and TX state enums;
  - a function computing parity for a given mode.
- One natural sub-module: uart_sync_fifo (DATA_BITS wide, FIFO_DEPTH deep, push/pop/full/empty/count).
- RX and TX stay inline.

Test Plan:
- DATA_BITS=8, PARITY=2, echo_en=1, cts_n=0: send 0xA5 on rxd -> rx_vld with rx_dat=0xA5, pty_err=0. txd then carries frame 0xA5 with parity bit 0, starting 2 cycles after the FIFO write.
- Send 0x3C with the parity bit flipped -> pty_err=1 with rx_vld. The character is echoed, or not echoed with UART_ECHO_ERRDROP_EN.
- Send 0x55 with the stop bit held 0 -> frm_err=1. The receiver re-syncs and the next frame 0x81 is received correctly.
- FIFO_DEPTH=4, cts_n=1, send 6 characters -> fifo_cnt saturates at 4 and ovf pulses twice. Release cts_n -> the first 4 characters are sent in order.
- 0.3-bit low glitch on rxd -> no rx_vld.
- echo_en=0, wr_en with 0x12, 0x34; rst asserted mid-frame of 0x12 -> txd=1 the next cycle, fifo_cnt=0, and nothing further is transmitted.
